// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - accepts one ALU request, drives registered operands, waits for settle, returns the captured result
module alu_op_sequencer #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_alu_op,
    input  logic [2:0]  req_funct3,
    input  logic        req_funct7_5,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_err_q, rsp_err_d;

    logic        dec_legal;
    logic [3:0]  dec_ctrl;

    // Only the listed R-type funct combinations are supported; everything else flags an error.
    always_comb begin
        dec_legal = 1'b1;
        dec_ctrl  = 4'b0000;
        case (req_alu_op)
            2'b00: dec_ctrl = 4'b0010;
            2'b01: dec_ctrl = 4'b0110;
            2'b10: begin
                case ({req_funct7_5, req_funct3})
                    4'b0_000: dec_ctrl = 4'b0010;
                    4'b1_000: dec_ctrl = 4'b0110;
                    4'b0_111: dec_ctrl = 4'b0000;
                    4'b0_110: dec_ctrl = 4'b0001;
                    4'b0_010: dec_ctrl = 4'b0111;
                    4'b1_100: dec_ctrl = 4'b1100;
                    default:  dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            alu_a_q      <= 32'd0;
            alu_b_q      <= 32'd0;
            alu_ctrl_q   <= 4'd0;
            rsp_result_q <= 32'd0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (dec_legal) begin
                        alu_a_d    = req_a;
                        alu_b_d    = req_b;
                        alu_ctrl_d = dec_ctrl;
                        cnt_d      = CNT_LOAD;
                        state_d    = S_WAIT;
                    end else begin
                        // Illegal ops never touch the ALU operands and skip the settle wait.
                        rsp_result_d = 32'd0;
                        rsp_zero_d   = 1'b0;
                        rsp_err_d    = 1'b1;
                        state_d      = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_result_d = alu_result;
                    rsp_zero_d   = alu_zero;
                    rsp_err_d    = 1'b0;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_ctrl_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning ALU settle cycles between operand drive and result capture (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  request offered.
REQ-005 SHALL have port req_ready  output  1  sequencer can accept a request.
REQ-006 SHALL have port req_alu_op  input  2  main-decoder op class.
REQ-007 SHALL have port req_funct3  input  3  instruction funct3.
REQ-008 SHALL have port req_funct7_5  input  1  instruction bit 30.
REQ-009 SHALL have ports req_a, req_b  input  32 each  operands.
REQ-010 SHALL have ports alu_a, alu_b  output  32 each  registered operands driven to the ALU.
REQ-011 SHALL have port alu_control  output  4  registered ALU operation select.
REQ-012 SHALL have port alu_result  input  32  ALU result.
REQ-013 SHALL have port alu_zero  input  1  ALU zero flag.
REQ-014 SHALL have port rsp_valid  output  1  response available.
REQ-015 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-016 SHALL have ports rsp_result  output  32, rsp_zero  output  1, rsp_err  output  1  captured result, zero flag, illegal-op flag.

Function
REQ-017 SHALL implement states IDLE, WAIT, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-018 SHALL accept a request on an edge where state=IDLE and req_valid=1; no acceptance in any other state.
REQ-019 SHALL decode: alu_op 00 -> 0010 (add); 01 -> 0110 (sub); 10 with {funct7_5,funct3} 0_000 -> 0010, 1_000 -> 0110, 0_111 -> 0000 (and), 0_110 -> 0001 (or), 0_010 -> 0111 (slt), 1_100 -> 1100 (nor).
REQ-020 SHALL treat every other alu_op/funct combination, including alu_op 11, as illegal.
REQ-021 On legal acceptance SHALL register alu_a=req_a, alu_b=req_b, alu_control=decoded code, load wait counter with WAIT_CYCLES-1, enter WAIT.
REQ-022 In WAIT with counter nonzero SHALL decrement counter; with counter zero SHALL capture rsp_result=alu_result, rsp_zero=alu_zero, rsp_err=0, enter RESP.
REQ-023 Latency: request accepted at edge k SHALL yield rsp_valid=1 after edge k+WAIT_CYCLES.
REQ-024 On illegal acceptance SHALL leave alu_a/alu_b/alu_control unchanged, set rsp_result=0, rsp_zero=0, rsp_err=1, enter RESP directly (rsp_valid after edge k).
REQ-025 In RESP SHALL hold rsp_valid and all rsp_* stable until an edge with rsp_ready=1, then enter IDLE.
REQ-026 SHALL NOT accept a new request on the same edge a response completes; next acceptance earliest one edge later.
REQ-027 alu_a, alu_b, alu_control SHALL remain stable throughout WAIT and RESP.
REQ-028 Counter SHALL be 4 bits; no wrap-around occurs since it stops at zero.

Reset
REQ-029 reset=1 SHALL immediately force state IDLE, counter 0, alu_a=0, alu_b=0, alu_control=0000, rsp_result=0, rsp_zero=0, rsp_err=0, rsp_valid=0, req_ready=1 after release.
REQ-030 Reset asserted in WAIT or RESP SHALL discard the in-flight transaction; no response is produced after release.

Verification
REQ-031 Add: alu_op=10, f7_5=0, f3=000, a=5, b=7, ALU model returns 12 -> alu_control=0010, rsp_result=12, rsp_zero=0, rsp_valid one edge after accept (WAIT_CYCLES=1).
REQ-032 Sub zero: alu_op=01, a=b=0x1234, ALU returns 0 with zero=1 -> alu_control=0110, rsp_result=0, rsp_zero=1, rsp_err=0.
REQ-033 Illegal: alu_op=11 -> rsp_err=1, rsp_result=0, rsp_valid after accept edge, alu_control unchanged.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result held, req_ready=0; rsp_ready=1 -> IDLE next edge, req_ready=1.
REQ-035 WAIT_CYCLES=4: accept at edge k -> rsp_valid after edge k+4; ALU inputs stable edges k..k+4.
REQ-036 Reset mid-WAIT: assert reset during WAIT -> outputs zero immediately, rsp_valid never asserts for that request.
